nibble_deserializer: RTL



---
 rtl/deser_pkg.sv | 9 +
 rtl/deser_bit_counter.sv | 36 +++
 rtl/nibble_deserializer.sv | 103 ++++++++++
 3 files changed

// File: rtl/deser_pkg.sv
// Shared types and constants for the serial-to-parallel word deserializer.
package deser_pkg;
  localparam int DESER_WIDTH = 4;

  typedef enum logic {
    COLLECT = 1'b0,
    PENDING = 1'b1
  } state_e;
endpackage

// File: rtl/deser_bit_counter.sv
// Modulo-WIDTH bit counter with increment, clear and terminal-count flag.
module deser_bit_counter
  import deser_pkg::*;
#(
  parameter int WIDTH = DESER_WIDTH
) (
  input  logic clk,
  input  logic reset,
  input  logic inc_i,
  input  logic clr_i,
  output logic tc_o
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign tc_o = (cnt_q == CW'(WIDTH - 1));

  // A clear with a same-cycle increment counts that bit as bit 0.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = inc_i ? CW'(1) : '0;
    end else if (inc_i) begin
      cnt_d = tc_o ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/nibble_deserializer.sv
// Assembles WIDTH-bit words from a bit stream; registered valid/ready
// output with a one-word pending buffer that backpressures the input.
module nibble_deserializer
  import deser_pkg::*;
#(
  parameter int WIDTH     = DESER_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sin,
  input  logic             sin_valid,
  output logic             sin_ready,
  input  logic             frame,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready
);
  state_e           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             vld_q, vld_d;
  logic [WIDTH-1:0] shifted;
  logic             accept;
  logic             consume;
  logic             cnt_clr;
  logic             cnt_tc;
  logic             word_done;

  assign sin_ready  = (state_q == COLLECT) && !reset;
  assign accept     = sin_valid && sin_ready;
  assign consume    = vld_q && dout_ready;
  assign cnt_clr    = frame && (state_q == COLLECT);
  assign word_done  = accept && cnt_tc && !cnt_clr;
  assign dout       = dout_q;
  assign dout_valid = vld_q;

  deser_bit_counter #(
    .WIDTH(WIDTH)
  ) u_cnt (
    .clk  (clk),
    .reset(reset),
    .inc_i(accept),
    .clr_i(cnt_clr),
    .tc_o (cnt_tc)
  );

  // Stale bits left by a frame resync are shifted out before completion.
  always_comb begin
    if (MSB_FIRST) begin
      shifted = {sr_q[WIDTH-2:0], sin};
    end else begin
      shifted = {sin, sr_q[WIDTH-1:1]};
    end
  end

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    dout_d  = dout_q;
    vld_d   = vld_q;
    if (consume) begin
      vld_d = 1'b0;
    end
    unique case (state_q)
      COLLECT: begin
        if (accept) begin
          sr_d = shifted;
          if (word_done) begin
            if (!vld_q || dout_ready) begin
              dout_d = shifted;
              vld_d  = 1'b1;
            end else begin
              state_d = PENDING;
            end
          end
        end
      end
      PENDING: begin
        if (consume) begin
          dout_d  = sr_q;
          vld_d   = 1'b1;
          state_d = COLLECT;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= COLLECT;
      sr_q    <= '0;
      dout_q  <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      dout_q  <= dout_d;
      vld_q   <= vld_d;
    end
  end
endmodule
